// File: rtl/sr_ff_behavior.sv
// Clocked set/reset flip-flop bank with complementary outputs and an
// S=R=1 flag. Each of the WIDTH bits is fully independent.
//
// Ports:
//   clk     : clock, all state changes on the rising edge
//   rst     : synchronous active-high reset (q <= RESET_VAL, invalid <= 0)
//   s       : per-bit set request
//   r       : per-bit clear request
//   q       : registered state
//   qbar    : always ~q, derived from the q register
//   invalid : registered flag, 1 where S=R=1 was sampled on the last edge
//
// SR_BOTH_MODE selects the action on S=R=1:
//   0 hold, 1 clear wins, 2 set wins, 3 toggle.
module sr_ff_behavior #(
    parameter int unsigned          WIDTH        = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL    = '0,
    parameter int unsigned          SR_BOTH_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] invalid
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] inv_q;
    logic [WIDTH-1:0] inv_d;

    // Value a bit takes when both requests are present.
    function automatic logic both_val(input logic cur);
        logic v;
        v = cur;
        case (SR_BOTH_MODE)
            1:       v = 1'b0;
            2:       v = 1'b1;
            3:       v = ~cur;
            default: v = cur;
        endcase
        return v;
    endfunction

    always_comb begin
        q_d   = q_q;
        inv_d = s & r;
        for (int i = 0; i < int'(WIDTH); i++) begin
            case ({s[i], r[i]})
                2'b10:   q_d[i] = 1'b1;
                2'b01:   q_d[i] = 1'b0;
                2'b11:   q_d[i] = both_val(q_q[i]);
                default: q_d[i] = q_q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= RESET_VAL;
            inv_q <= '0;
        end else begin
            q_q   <= q_d;
            inv_q <= inv_d;
        end
    end

    assign q       = q_q;
    assign qbar    = ~q_q;
    assign invalid = inv_q;

endmodule

// File: tb/tb_sr_ff_behavior.sv
// Scoreboard bench: four 4-bit instances, one per SR_BOTH_MODE, share
// stimulus; expected q/invalid per edge are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_sr_ff_behavior;

    typedef struct packed {
        logic [15:0] q;   // {mode3, mode2, mode1, mode0}
        logic [3:0]  inv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] q_w    [4];
    logic [3:0] qbar_w [4];
    logic [3:0] inv_w  [4];

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    bit   done  = 1'b0;

    always #10 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        sr_ff_behavior #(
            .WIDTH       (4),
            .RESET_VAL   (4'b0000),
            .SR_BOTH_MODE(m)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .s      (s),
            .r      (r),
            .q      (q_w[m]),
            .qbar   (qbar_w[m]),
            .invalid(inv_w[m])
        );
    end

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Monitor: every edge presents a result one step after the inputs.
    always @(posedge clk) begin
        #1;
        if (!done && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            for (int m = 0; m < 4; m++) begin
                chk($sformatf("q[m%0d]", m), q_w[m], e.q[m*4 +: 4]);
                chk($sformatf("qbar[m%0d]", m), qbar_w[m],
                    ~e.q[m*4 +: 4]);
                chk($sformatf("invalid[m%0d]", m), inv_w[m], e.inv);
            end
        end
    end

    task automatic step(input logic rs, input logic [3:0] sv,
                        input logic [3:0] rv,
                        input logic [3:0] e0, input logic [3:0] e1,
                        input logic [3:0] e2, input logic [3:0] e3,
                        input logic [3:0] inv);
        exp_t e;
        @(negedge clk);
        rst = rs;
        s   = sv;
        r   = rv;
        e.q   = {e3, e2, e1, e0};
        e.inv = inv;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        s   = 4'b1111;
        r   = 4'b0000;
        begin
            exp_t e;
            e.q   = 16'h0000;
            e.inv = 4'b0000;
            sb.push_back(e);
        end
        // set for 100 ns, then clear for 100 ns
        repeat (5) step(0, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
        repeat (5) step(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        // hold from 0, then set and hold from 1
        repeat (5) step(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        step(0, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
        repeat (5) step(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
        // forbidden input from q=1: hold / clear / set / toggle
        step(0, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
        step(0, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF);
        step(0, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
        step(0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0);
        // glitch on s strictly between edges
        step(0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0);
        #3 s = 4'hF;
        #4 s = 4'h0;
        // mid-operation reset, then per-bit independence
        step(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        step(0, 4'h5, 4'hA, 4'h5, 4'h5, 4'h5, 4'h5, 4'h0);
        step(0, 4'h8, 4'h8, 4'h5, 4'h5, 4'hD, 4'hD, 4'h8);
        step(0, 4'h0, 4'h0, 4'h5, 4'h5, 4'hD, 4'hD, 4'h0);
        // reset overrides S=R=1
        step(1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        step(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
